// File: rtl/pdm_demod_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pdm_pkg                                                      |
// | Description : Definitions shared by the PDM modulator and demodulator:     |
// |               sample width, CIC order, accumulator width helper and the    |
// |               demodulator warm-up state encoding.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pdm_pkg;

  // Sample width common to the modulator input and the demodulator output.
  localparam int PDM_WIDTH = 10;

  // Number of integrator / comb pairs in the decimator.
  localparam int CIC_ORDER = 2;

  // An order-2 CIC with ratio 2^dec_log2 has a DC gain of 2^(2*dec_log2);
  // one extra bit holds the full-scale value itself.
  function automatic int cic_acc_width(input int dec_log2);
    return 2 * dec_log2 + 1;
  endfunction

  // Warm-up sequencing: the first two decimated results are discarded
  // because the comb delays still hold reset state.
  typedef enum logic [1:0] {
    WU_FLUSH0 = 2'd0,
    WU_FLUSH1 = 2'd1,
    WU_RUN    = 2'd2
  } warm_state_e;

endpackage
`default_nettype wire

// File: rtl/pdm_demod_cic_integrator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cic_integrator                                               |
// | Description : One CIC integrator stage. Adds in_i to the accumulator on    |
// |               enabled cycles; the sum wraps modulo 2^AW by design.         |
// | Ports       : clk, rst (sync, active-high), en_i (accumulate strobe),      |
// |               in_i (AW-bit addend), acc_o (registered accumulator).        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cic_integrator #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic [AW-1:0] in_i,
  output logic [AW-1:0] acc_o
);

  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_d;

  // Modular wrap is what makes the comb differences come out exact.
  assign acc_d = acc_q + in_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/pdm_demod.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pdm_demod                                                    |
// | Description : PDM bit stream to WIDTH-bit unsigned sample. Second-order    |
// |               CIC decimator, ratio R = 2^DEC_LOG2, followed by a right     |
// |               shift and saturation to the output width.                    |
// | Ports       : clk, rst (sync, active-high)                                 |
// |               din        - PDM bit, consumed when din_en = 1               |
// |               din_en     - bit strobe                                      |
// |               dout       - decoded sample, updated with dout_valid         |
// |               dout_valid - one-cycle pulse per R enabled bits              |
// |               settled    - high once the warm-up outputs have flushed      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pdm_demod
  import pdm_pkg::*;
#(
  parameter int WIDTH    = PDM_WIDTH,
  parameter int DEC_LOG2 = 5,
  parameter int SYNC_IN  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             settled
);

  localparam int AW    = cic_acc_width(DEC_LOG2);
  localparam int SHIFT = 2 * DEC_LOG2 - WIDTH;

  // Largest representable output, widened to the accumulator width.
  localparam logic [AW-1:0] Y_MAX = {{(AW - WIDTH){1'b0}}, {WIDTH{1'b1}}};

  // ---------------------------------------------------------------------------
  // Input conditioning. The strobe travels through the same two flops as the
  // data so each bit stays paired with its own enable.
  // ---------------------------------------------------------------------------
  logic bit_s;
  logic bit_en_s;

  generate
    if (SYNC_IN != 0) begin : g_sync
      logic [1:0] din_sync_q;
      logic [1:0] en_sync_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          din_sync_q <= '0;
          en_sync_q  <= '0;
        end else begin
          din_sync_q <= {din_sync_q[0], din};
          en_sync_q  <= {en_sync_q[0], din_en};
        end
      end

      assign bit_s    = din_sync_q[1];
      assign bit_en_s = en_sync_q[1];
    end else begin : g_nosync
      assign bit_s    = din;
      assign bit_en_s = din_en;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Integrators. Stage 2 accumulates the value stage 1 is about to hold
  // (i1 + x), so there is no pipeline bubble between the stages.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] x_ext;
  logic [AW-1:0] i1_acc;
  logic [AW-1:0] i1_next;
  logic [AW-1:0] i2_acc;

  assign x_ext   = {{(AW - 1){1'b0}}, bit_s};
  assign i1_next = i1_acc + x_ext;

  cic_integrator #(
    .AW (AW)
  ) u_int1 (
    .clk   (clk),
    .rst   (rst),
    .en_i  (bit_en_s),
    .in_i  (x_ext),
    .acc_o (i1_acc)
  );

  cic_integrator #(
    .AW (AW)
  ) u_int2 (
    .clk   (clk),
    .rst   (rst),
    .en_i  (bit_en_s),
    .in_i  (i1_next),
    .acc_o (i2_acc)
  );

  // ---------------------------------------------------------------------------
  // Decimation counter. The strobe is registered, so on the cycle it is high
  // i2 already includes the R-th bit of the period.
  // ---------------------------------------------------------------------------
  logic [DEC_LOG2-1:0] dcnt_q;
  logic                dec_stb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt_q    <= '0;
      dec_stb_q <= 1'b0;
    end else begin
      dec_stb_q <= bit_en_s && (dcnt_q == {DEC_LOG2{1'b1}});
      if (bit_en_s) begin
        dcnt_q <= dcnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Comb stage, evaluated once per decimated sample.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] i2_dly_q;
  logic [AW-1:0] c1_dly_q;
  logic [AW-1:0] c2_q;
  logic          comb_stb_q;
  logic [AW-1:0] c1_d;
  logic [AW-1:0] c2_d;

  assign c1_d = i2_acc - i2_dly_q;
  assign c2_d = c1_d - c1_dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      i2_dly_q   <= '0;
      c1_dly_q   <= '0;
      c2_q       <= '0;
      comb_stb_q <= 1'b0;
    end else begin
      comb_stb_q <= dec_stb_q;
      if (dec_stb_q) begin
        i2_dly_q <= i2_acc;
        c1_dly_q <= c1_d;
        c2_q     <= c2_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scaling and saturation. Only an all-ones window reaches R^2, one above
  // the largest WIDTH-bit code.
  // ---------------------------------------------------------------------------
  logic [AW-1:0]    y_scaled;
  logic [WIDTH-1:0] dout_d;

  assign y_scaled = c2_q >> SHIFT;
  assign dout_d   = (y_scaled > Y_MAX) ? {WIDTH{1'b1}} : y_scaled[WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Warm-up sequencer and output register.
  // ---------------------------------------------------------------------------
  warm_state_e      warm_q;
  logic [WIDTH-1:0] dout_q;
  logic             dout_valid_q;
  logic             settled_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      warm_q       <= WU_FLUSH0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      settled_q    <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      if (comb_stb_q) begin
        case (warm_q)
          WU_FLUSH0: warm_q <= WU_FLUSH1;
          WU_FLUSH1: warm_q <= WU_RUN;
          WU_RUN: begin
            dout_q       <= dout_d;
            dout_valid_q <= 1'b1;
            settled_q    <= 1'b1;
          end
          default:   warm_q <= WU_FLUSH0;
        endcase
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign settled    = settled_q;

endmodule
`default_nettype wire

// File: tb/tb_pdm_demod.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pdm_demod                                                 |
// | Description : Self-checking bench for pdm_demod (SYNC_IN = 0). A          |
// |               triangular-window reference computes every expected sample  |
// |               from the enabled-bit history and queues it; a negedge       |
// |               monitor pops and compares on each dout_valid. Scenario      |
// |               tasks check timing, periods and fixed values inline.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pdm_demod;

  localparam int WIDTH = 10;
  localparam int DL    = 5;
  localparam int R     = 1 << DL;
  localparam int NH    = 2 * R - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             din;
  logic             din_en;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             settled;

  always #5 clk = ~clk;

  pdm_demod #(
    .WIDTH    (WIDTH),
    .DEC_LOG2 (DL),
    .SYNC_IN  (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_en     (din_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .settled    (settled)
  );

  int checks = 0;
  int errors = 0;
  int rel_cyc = 0;
  int valid_cnt = 0;

  // Reference model state.
  logic [NH-1:0]    hist;
  int               bits_since_rst;
  int               dec_since_rst;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] mon_exp;

  // Order-2 CIC impulse response: triangle 1,2,..,R,..,2,1 over 2R-1 bits.
  function automatic logic [WIDTH-1:0] cic_ref(input logic [NH-1:0] bits);
    int s;
    s = 0;
    for (int k = 0; k < NH; k++) begin
      if (bits[k]) s += (k < R) ? (k + 1) : (2 * R - 1 - k);
    end
    if (s > (1 << WIDTH) - 1) s = (1 << WIDTH) - 1;
    return WIDTH'(s);
  endfunction

  task automatic model_bit(input logic b);
    hist = {hist[NH-2:0], b};
    bits_since_rst++;
    if (bits_since_rst % R == 0) begin
      dec_since_rst++;
      if (dec_since_rst >= 3) exp_q.push_back(cic_ref(hist));
    end
  endtask

  task automatic model_clear();
    hist           = '0;
    bits_since_rst = 0;
    dec_since_rst  = 0;
    exp_q.delete();
  endtask

  // Called at a negedge; drives one cycle and returns at the next negedge.
  task automatic step(input logic b, input logic en);
    din    = b;
    din_en = en;
    @(posedge clk);
    rel_cyc++;
    if (en && !rst) model_bit(b);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst    = 1'b1;
    din    = 1'b0;
    din_en = 1'b0;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    rst     = 1'b0;
    rel_cyc = 0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && dout_valid) begin
      valid_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected: dout_valid with dout=%0d at rel cycle %0d, no sample expected", dout, rel_cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (dout !== mon_exp) begin
          errors++;
          $display("FAIL scoreboard_dout: got %0d expected %0d at rel cycle %0d", dout, mon_exp, rel_cyc);
        end
      end
      checks++;
      if (settled !== 1'b1) begin
        errors++;
        $display("FAIL settled_with_valid: got %b expected 1 at rel cycle %0d", settled, rel_cyc);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    for (int n = 0; n < 3; n++) step(1'b1, 1'b1);
    checks++;
    if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %0d expected 0", dout); end
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", dout_valid); end
    checks++;
    if (settled !== 1'b0) begin errors++; $display("FAIL reset_settled: got %b expected 0", settled); end
  endtask

  task automatic test_zeros();
    int first;
    first = -1;
    apply_reset();
    for (int n = 0; n < 200 && first < 0; n++) begin
      step(1'b0, 1'b1);
      if (settled === 1'b1 || dout_valid === 1'b1) begin
        first = rel_cyc;
        checks++;
        if (dout_valid !== 1'b1 || settled !== 1'b1) begin
          errors++;
          $display("FAIL zeros_rise_together: valid=%b settled=%b, both required 1", dout_valid, settled);
        end
        checks++;
        if (dout !== '0) begin errors++; $display("FAIL zeros_dout: got %0d expected 0", dout); end
      end
    end
    checks++;
    if (first != 3 * R + 2) begin
      errors++;
      $display("FAIL zeros_first_valid: got rel cycle %0d expected %0d", first, 3 * R + 2);
    end
    for (int n = 0; n < 2 * R; n++) step(1'b0, 1'b1);
    checks++;
    if (settled !== 1'b1) begin errors++; $display("FAIL zeros_settled_hold: got %b expected 1", settled); end
  endtask

  task automatic test_ones();
    int base;
    apply_reset();
    base = valid_cnt;
    for (int n = 0; n < 3 * R + 2 + 999 * R; n++) step(1'b1, 1'b1);
    #1;
    checks++;
    if (valid_cnt - base != 1000) begin
      errors++;
      $display("FAIL ones_count: got %0d outputs expected 1000", valid_cnt - base);
    end
    checks++;
    if (dout !== 10'd1023) begin errors++; $display("FAIL ones_clamp: got %0d expected 1023", dout); end
  endtask

  task automatic test_alternating();
    int prev;
    int nv;
    logic b;
    prev = -1;
    nv   = 0;
    b    = 1'b1;
    apply_reset();
    for (int n = 0; n < 3 * R + 2 + 12 * R; n++) begin
      step(b, 1'b1);
      b = ~b;
      if (dout_valid === 1'b1) begin
        nv++;
        checks++;
        if (dout !== 10'd512) begin errors++; $display("FAIL alt_dout: got %0d expected 512", dout); end
        if (prev >= 0) begin
          checks++;
          if (rel_cyc - prev != R) begin
            errors++;
            $display("FAIL alt_period: got %0d cycles expected %0d", rel_cyc - prev, R);
          end
        end
        prev = rel_cyc;
      end
    end
    checks++;
    if (nv != 13) begin errors++; $display("FAIL alt_count: got %0d outputs expected 13", nv); end
  endtask

  task automatic test_sparse();
    int prev;
    int nv;
    logic b;
    logic en;
    prev = -1;
    nv   = 0;
    b    = 1'b1;
    apply_reset();
    for (int n = 0; n < 9 * R + 2 + 4 * 3 * R; n++) begin
      en = (n % 3 == 2);
      step(en ? b : 1'($urandom_range(0, 1)), en);
      if (en) b = ~b;
      if (dout_valid === 1'b1) begin
        nv++;
        checks++;
        if (dout !== 10'd512) begin errors++; $display("FAIL sparse_dout: got %0d expected 512", dout); end
        if (prev >= 0) begin
          checks++;
          if (rel_cyc - prev != 3 * R) begin
            errors++;
            $display("FAIL sparse_period: got %0d cycles expected %0d", rel_cyc - prev, 3 * R);
          end
        end
        prev = rel_cyc;
      end
    end
    checks++;
    if (nv != 5) begin errors++; $display("FAIL sparse_count: got %0d outputs expected 5", nv); end
  endtask

  // First-order sigma-delta modulator model feeding the decoder.
  task automatic test_loopback();
    int acc;
    int nv;
    logic b;
    acc = 0;
    nv  = 0;
    apply_reset();
    for (int n = 0; n < 3 * R + 2 + 15 * R; n++) begin
      acc += 300;
      b = (acc >= 1024);
      if (b) acc -= 1024;
      step(b, 1'b1);
      if (dout_valid === 1'b1) begin
        nv++;
        checks++;
        if (dout < 10'd296 || dout > 10'd304) begin
          errors++;
          $display("FAIL loopback_range: got %0d expected 300+-4", dout);
        end
      end
    end
    checks++;
    if (nv != 16) begin errors++; $display("FAIL loopback_count: got %0d outputs expected 16", nv); end
  endtask

  task automatic test_random();
    int base;
    int want;
    apply_reset();
    base = valid_cnt;
    for (int n = 0; n < 4000; n++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    for (int n = 0; n < 3; n++) step(1'b0, 1'b0);
    #1;
    want = (dec_since_rst > 2) ? dec_since_rst - 2 : 0;
    checks++;
    if (valid_cnt - base != want) begin
      errors++;
      $display("FAIL random_count: got %0d outputs expected %0d", valid_cnt - base, want);
    end
  endtask

  task automatic test_mid_reset();
    int nv;
    int first;
    logic b;
    nv    = 0;
    first = -1;
    b     = 1'b1;
    apply_reset();
    for (int n = 0; n < 400 && nv < 3; n++) begin
      step(b, 1'b1);
      b = ~b;
      if (dout_valid === 1'b1) nv++;
    end
    checks++;
    if (nv != 3) begin errors++; $display("FAIL midrst_warm: got %0d outputs expected 3", nv); end
    // Two bits of the new period are already in; 15 more reach dcnt = 17.
    for (int n = 0; n < 15; n++) begin
      step(b, 1'b1);
      b = ~b;
    end
    rst    = 1'b1;
    din    = b;
    din_en = 1'b1;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    checks++;
    if (dout !== '0) begin errors++; $display("FAIL midrst_dout: got %0d expected 0", dout); end
    checks++;
    if (settled !== 1'b0) begin errors++; $display("FAIL midrst_settled: got %b expected 0", settled); end
    rst     = 1'b0;
    rel_cyc = 0;
    for (int n = 0; n < 200 && first < 0; n++) begin
      step(b, 1'b1);
      b = ~b;
      if (dout_valid === 1'b1 || settled === 1'b1) begin
        first = rel_cyc;
        checks++;
        if (dout !== 10'd512) begin errors++; $display("FAIL midrst_dout_after: got %0d expected 512", dout); end
      end
    end
    checks++;
    if (first != 3 * R + 2) begin
      errors++;
      $display("FAIL midrst_first_valid: got rel cycle %0d expected %0d", first, 3 * R + 2);
    end
  endtask

  initial begin
    rst    = 1'b1;
    din    = 1'b0;
    din_en = 1'b0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_zeros();
    test_ones();
    test_alternating();
    test_sparse();
    test_loopback();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
